// File: rtl/game_pkg.sv
`default_nettype none
// ============================================================================
// Module      : game_pkg
// Description : Shared state encoding and default parameter values for the
//               code-guessing game (code_checker and its helpers).
// Revision    : 1.0 - initial release
// ============================================================================
package game_pkg;

  // Round state machine encoding
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    PLAY  = 3'd1,
    MOTOR = 3'd2,
    WIN   = 3'd3,
    LOSE  = 3'd4
  } state_t;

  // Default tuning values for a round
  localparam int DEFAULT_MAX_TRIES      = 3;
  localparam int DEFAULT_TIMEOUT_CYCLES = 8;
  localparam int DEFAULT_MOTOR_UNIT     = 4;

endpackage : game_pkg
`default_nettype wire

// File: rtl/down_counter.sv
`default_nettype none
// ============================================================================
// Module      : down_counter
// Description : Loadable down-counter. Load wins over decrement; the count
//               saturates at zero. term is high while the count equals 1, so
//               a value N loaded on one edge gives term on the N-th cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module down_counter #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,     // asynchronous, active-low
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             dec,
  output logic             term
);

  logic [WIDTH-1:0] count_d;
  logic [WIDTH-1:0] count_q;

  // Next count: load has priority, decrement stops at zero
  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = load_val;
    end else if (dec && (count_q != '0)) begin
      count_d = count_q - WIDTH'(1);
    end
  end

  // Count register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign term = (count_q == WIDTH'(1));

endmodule : down_counter
`default_nettype wire

// File: rtl/code_checker.sv
`default_nettype none
// ============================================================================
// Module      : code_checker
// Description : Latches a 4-bit secret code from the random stream on start,
//               scores up to MAX_TRIES timed guesses with a per-bit match
//               mask, and on a correct guess runs the motor for a duration
//               taken from the same random value; otherwise reports a loss.
// Revision    : 1.0 - initial release
// ============================================================================
module code_checker
  import game_pkg::*;
#(
  parameter int MAX_TRIES      = DEFAULT_MAX_TRIES,
  parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES,
  parameter int MOTOR_UNIT     = DEFAULT_MOTOR_UNIT
) (
  input  logic                           clk,
  input  logic                           reset,      // asynchronous, active-low
  input  logic [7:0]                     rnd_in,
  input  logic                           start,
  input  logic [3:0]                     guess,
  input  logic                           submit,
  output logic                           busy,
  output logic                           win,
  output logic                           lose,
  output logic [$clog2(MAX_TRIES+1)-1:0] tries_left,
  output logic [3:0]                     match_mask,
  output logic                           motor_en,
  output logic [1:0]                     motor_dir,
  output logic [1:0]                     motor_dur
);

  localparam int TRW = $clog2(MAX_TRIES + 1);
  // Timer must hold TIMEOUT_CYCLES; motor counter must hold 4*MOTOR_UNIT
  localparam int TMW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int MOW = $clog2(4 * MOTOR_UNIT + 1);

  state_t           state_d,      state_q;
  logic [3:0]       code_d,       code_q;
  logic [TRW-1:0]   tries_d,      tries_q;
  logic [3:0]       mask_d,       mask_q;
  logic             win_d,        win_q;
  logic             lose_d,       lose_q;
  logic             motor_en_d,   motor_en_q;
  logic [1:0]       motor_dir_d,  motor_dir_q;
  logic [1:0]       motor_dur_d,  motor_dur_q;

  logic             tmr_load;
  logic             tmr_dec;
  logic             tmr_term;
  logic             mot_load;
  logic             mot_dec;
  logic             mot_term;
  logic [MOW-1:0]   mot_load_val;
  logic             miss;

  // Upper random bits carry nothing this block needs
  logic             unused_rnd_hi;
  assign unused_rnd_hi = ^rnd_in[7:4];

  // Run length in cycles from the duration latched at start
  assign mot_load_val = MOW'((32'(motor_dur_q) + 32'd1) * 32'(MOTOR_UNIT));

  // Per-attempt timeout timer
  down_counter #(
    .WIDTH (TMW)
  ) u_attempt_timer (
    .clk      (clk),
    .reset    (reset),
    .load     (tmr_load),
    .load_val (TMW'(TIMEOUT_CYCLES)),
    .dec      (tmr_dec),
    .term     (tmr_term)
  );

  // Motor run-length counter
  down_counter #(
    .WIDTH (MOW)
  ) u_motor_timer (
    .clk      (clk),
    .reset    (reset),
    .load     (mot_load),
    .load_val (mot_load_val),
    .dec      (mot_dec),
    .term     (mot_term)
  );

  // Next-state, scoring and counter control
  always_comb begin
    state_d     = state_q;
    code_d      = code_q;
    tries_d     = tries_q;
    mask_d      = mask_q;
    win_d       = win_q;
    lose_d      = lose_q;
    motor_en_d  = motor_en_q;
    motor_dir_d = motor_dir_q;
    motor_dur_d = motor_dur_q;
    tmr_load    = 1'b0;
    tmr_dec     = 1'b0;
    mot_load    = 1'b0;
    mot_dec     = 1'b0;
    miss        = 1'b0;

    unique case (state_q)
      IDLE, WIN, LOSE: begin
        // start wins over a simultaneous submit; submit alone is ignored
        if (start) begin
          state_d     = PLAY;
          code_d      = rnd_in[3:0];
          motor_dir_d = {rnd_in[0], rnd_in[2]};
          motor_dur_d = {rnd_in[1], rnd_in[3]};
          tries_d     = TRW'(MAX_TRIES);
          tmr_load    = 1'b1;
          mask_d      = 4'h0;
          win_d       = 1'b0;
          lose_d      = 1'b0;
        end
      end

      PLAY: begin
        if (submit) begin
          // A submit in the timeout cycle is scored; the timeout is dropped
          mask_d = ~(guess ^ code_q);
          if (guess == code_q) begin
            state_d    = MOTOR;
            win_d      = 1'b1;
            motor_en_d = 1'b1;
            mot_load   = 1'b1;
          end else begin
            miss = 1'b1;
          end
        end else if (tmr_term) begin
          mask_d = 4'h0;
          miss   = 1'b1;
        end else begin
          tmr_dec = 1'b1;
        end

        if (miss) begin
          tries_d = tries_q - TRW'(1);
          if (tries_q == TRW'(1)) begin
            state_d = LOSE;
            lose_d  = 1'b1;
          end else begin
            tmr_load = 1'b1;
          end
        end
      end

      MOTOR: begin
        mot_dec = 1'b1;
        if (mot_term) begin
          state_d    = WIN;
          motor_en_d = 1'b0;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and output registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      code_q      <= 4'h0;
      tries_q     <= '0;
      mask_q      <= 4'h0;
      win_q       <= 1'b0;
      lose_q      <= 1'b0;
      motor_en_q  <= 1'b0;
      motor_dir_q <= 2'b00;
      motor_dur_q <= 2'b00;
    end else begin
      state_q     <= state_d;
      code_q      <= code_d;
      tries_q     <= tries_d;
      mask_q      <= mask_d;
      win_q       <= win_d;
      lose_q      <= lose_d;
      motor_en_q  <= motor_en_d;
      motor_dir_q <= motor_dir_d;
      motor_dur_q <= motor_dur_d;
    end
  end

  assign busy       = (state_q == PLAY) || (state_q == MOTOR);
  assign win        = win_q;
  assign lose       = lose_q;
  assign tries_left = tries_q;
  assign match_mask = mask_q;
  assign motor_en   = motor_en_q;
  assign motor_dir  = motor_dir_q;
  assign motor_dur  = motor_dur_q;

endmodule : code_checker
`default_nettype wire

// File: tb/tb_code_checker.sv
`default_nettype none
// ============================================================================
// Module      : tb_code_checker
// Description : Directed self-checking bench for code_checker.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_code_checker;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [7:0] rnd_in = 8'h00;
  logic       start = 1'b0;
  logic [3:0] guess = 4'h0;
  logic       submit = 1'b0;
  logic       busy;
  logic       win;
  logic       lose;
  logic [1:0] tries_left;
  logic [3:0] match_mask;
  logic       motor_en;
  logic [1:0] motor_dir;
  logic [1:0] motor_dur;

  int checks = 0;
  int errors = 0;

  code_checker #(
    .MAX_TRIES      (3),
    .TIMEOUT_CYCLES (8),
    .MOTOR_UNIT     (4)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .rnd_in     (rnd_in),
    .start      (start),
    .guess      (guess),
    .submit     (submit),
    .busy       (busy),
    .win        (win),
    .lose       (lose),
    .tries_left (tries_left),
    .match_mask (match_mask),
    .motor_en   (motor_en),
    .motor_dir  (motor_dir),
    .motor_dur  (motor_dur)
  );

  always #5 clk = ~clk;

  // Advance one clock; outputs are sampled 1ns after the rising edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input logic [7:0] rnd);
    rnd_in = rnd;
    start  = 1'b1;
    tick();
    start  = 1'b0;
  endtask

  task automatic do_submit(input logic [3:0] g);
    guess  = g;
    submit = 1'b1;
    tick();
    submit = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    tick();
    tick();
    reset = 1'b1;
    tick();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %0h exp 0", busy); end
    checks++; if (win !== 1'b0) begin errors++; $display("FAIL reset_win got %0h exp 0", win); end
    checks++; if (lose !== 1'b0) begin errors++; $display("FAIL reset_lose got %0h exp 0", lose); end
    checks++; if (tries_left !== 2'd0) begin errors++; $display("FAIL reset_tries got %0h exp 0", tries_left); end
    checks++; if (match_mask !== 4'h0) begin errors++; $display("FAIL reset_mask got %0h exp 0", match_mask); end
    checks++; if (motor_en !== 1'b0) begin errors++; $display("FAIL reset_motor_en got %0h exp 0", motor_en); end
    checks++; if ({motor_dir, motor_dur} !== 4'h0) begin errors++; $display("FAIL reset_dir_dur got %0h exp 0", {motor_dir, motor_dur}); end
  endtask

  task automatic test_start_with_submit();
    // start and submit together in IDLE: start taken, submit ignored
    rnd_in = 8'h05;
    guess  = 4'h5;
    start  = 1'b1;
    submit = 1'b1;
    tick();
    start  = 1'b0;
    submit = 1'b0;
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL ss_busy got %0h exp 1", busy); end
    checks++; if (win !== 1'b0) begin errors++; $display("FAIL ss_win got %0h exp 0", win); end
    checks++; if (match_mask !== 4'h0) begin errors++; $display("FAIL ss_mask got %0h exp 0", match_mask); end
    checks++; if (tries_left !== 2'd3) begin errors++; $display("FAIL ss_tries got %0h exp 3", tries_left); end
    // finish the round with a win so the next test starts from WIN
    do_submit(4'h5);
    for (int i = 0; i < 8; i++) tick();
  endtask

  task automatic test_win_first();
    int cnt;
    do_start(8'hA5);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL win_busy_after_start got %0h exp 1", busy); end
    checks++; if (win !== 1'b0) begin errors++; $display("FAIL win_cleared_on_start got %0h exp 0", win); end
    checks++; if (motor_dir !== 2'b11) begin errors++; $display("FAIL win_dir got %0h exp 3", motor_dir); end
    checks++; if (motor_dur !== 2'b00) begin errors++; $display("FAIL win_dur got %0h exp 0", motor_dur); end
    do_submit(4'h5);
    checks++; if (match_mask !== 4'hF) begin errors++; $display("FAIL win_mask got %0h exp f", match_mask); end
    checks++; if (win !== 1'b1) begin errors++; $display("FAIL win_flag got %0h exp 1", win); end
    checks++; if (tries_left !== 2'd3) begin errors++; $display("FAIL win_tries got %0h exp 3", tries_left); end
    checks++; if (motor_en !== 1'b1) begin errors++; $display("FAIL win_motor_next_cycle got %0h exp 1", motor_en); end
    cnt = 0;
    while (motor_en === 1'b1 && cnt < 40) begin
      cnt++;
      tick();
    end
    checks++; if (cnt !== 4) begin errors++; $display("FAIL win_motor_cycles got %0d exp 4", cnt); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL win_busy_end got %0h exp 0", busy); end
    checks++; if (win !== 1'b1) begin errors++; $display("FAIL win_sticky got %0h exp 1", win); end
  endtask

  task automatic test_loss();
    logic [3:0] g  [3] = '{4'h4, 4'h4, 4'h0};
    logic [3:0] em [3] = '{4'hE, 4'hE, 4'hA};
    logic [1:0] et [3] = '{2'd2, 2'd1, 2'd0};
    do_start(8'h05);
    for (int i = 0; i < 3; i++) begin
      do_submit(g[i]);
      checks++; if (match_mask !== em[i]) begin errors++; $display("FAIL loss_mask%0d got %0h exp %0h", i, match_mask, em[i]); end
      checks++; if (tries_left !== et[i]) begin errors++; $display("FAIL loss_tries%0d got %0h exp %0h", i, tries_left, et[i]); end
      checks++; if (motor_en !== 1'b0) begin errors++; $display("FAIL loss_motor%0d got %0h exp 0", i, motor_en); end
    end
    checks++; if (lose !== 1'b1) begin errors++; $display("FAIL loss_lose got %0h exp 1", lose); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL loss_busy got %0h exp 0", busy); end
    // submit in LOSE is ignored
    do_submit(4'h5);
    checks++; if (match_mask !== 4'hA) begin errors++; $display("FAIL lose_submit_mask got %0h exp a", match_mask); end
    checks++; if (tries_left !== 2'd0) begin errors++; $display("FAIL lose_submit_tries got %0h exp 0", tries_left); end
    checks++; if ({win, lose, motor_en} !== 3'b010) begin errors++; $display("FAIL lose_submit_flags got %0h exp 2", {win, lose, motor_en}); end
  endtask

  task automatic test_timeout();
    do_start(8'h05);
    for (int i = 0; i < 7; i++) tick();
    checks++; if (tries_left !== 2'd3) begin errors++; $display("FAIL to_before got %0h exp 3", tries_left); end
    tick();
    checks++; if (tries_left !== 2'd2) begin errors++; $display("FAIL to_fire got %0h exp 2", tries_left); end
    checks++; if (match_mask !== 4'h0) begin errors++; $display("FAIL to_mask got %0h exp 0", match_mask); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL to_stay_play got %0h exp 1", busy); end
    // timer reloaded: 7 more idle cycles do not time out
    for (int i = 0; i < 7; i++) tick();
    checks++; if (tries_left !== 2'd2) begin errors++; $display("FAIL to_reload got %0h exp 2", tries_left); end
    // wrong guess in the timeout cycle: scored once, no extra decrement
    do_submit(4'h4);
    checks++; if (tries_left !== 2'd1) begin errors++; $display("FAIL to_prio_wrong_tries got %0h exp 1", tries_left); end
    checks++; if (match_mask !== 4'hE) begin errors++; $display("FAIL to_prio_wrong_mask got %0h exp e", match_mask); end
  endtask

  task automatic test_submit_on_timeout();
    // continues with tries_left = 1 and a freshly reloaded timer
    for (int i = 0; i < 7; i++) tick();
    do_submit(4'h5);
    checks++; if (win !== 1'b1) begin errors++; $display("FAIL tos_win got %0h exp 1", win); end
    checks++; if (lose !== 1'b0) begin errors++; $display("FAIL tos_lose got %0h exp 0", lose); end
    checks++; if (motor_en !== 1'b1) begin errors++; $display("FAIL tos_motor got %0h exp 1", motor_en); end
    checks++; if (tries_left !== 2'd1) begin errors++; $display("FAIL tos_tries got %0h exp 1", tries_left); end
    for (int i = 0; i < 8; i++) tick();
  endtask

  task automatic test_busy_protect();
    do_start(8'hA5);
    do_submit(4'h4);
    rnd_in = 8'h3C;
    start  = 1'b1;
    tick();
    start  = 1'b0;
    checks++; if (tries_left !== 2'd2) begin errors++; $display("FAIL bp_tries got %0h exp 2", tries_left); end
    checks++; if (motor_dir !== 2'b11) begin errors++; $display("FAIL bp_dir got %0h exp 3", motor_dir); end
    checks++; if (match_mask !== 4'hE) begin errors++; $display("FAIL bp_mask got %0h exp e", match_mask); end
    // code still 5, not C
    do_submit(4'h5);
    checks++; if (win !== 1'b1) begin errors++; $display("FAIL bp_code_kept got %0h exp 1", win); end
    for (int i = 0; i < 8; i++) tick();
  endtask

  task automatic test_reset_motor();
    do_start(8'h0A);
    checks++; if (motor_dur !== 2'b11) begin errors++; $display("FAIL rm_dur got %0h exp 3", motor_dur); end
    checks++; if (motor_dir !== 2'b00) begin errors++; $display("FAIL rm_dir got %0h exp 0", motor_dir); end
    do_submit(4'hA);
    for (int i = 0; i < 4; i++) tick();
    checks++; if (motor_en !== 1'b1) begin errors++; $display("FAIL rm_running got %0h exp 1", motor_en); end
    reset = 1'b0;
    #1;
    checks++; if ({motor_en, win, busy} !== 3'b000) begin errors++; $display("FAIL rm_async got %0h exp 0", {motor_en, win, busy}); end
    tick();
    reset = 1'b1;
    tick();
    checks++; if ({busy, win, lose, motor_en} !== 4'h0) begin errors++; $display("FAIL rm_after got %0h exp 0", {busy, win, lose, motor_en}); end
    checks++; if (tries_left !== 2'd0) begin errors++; $display("FAIL rm_tries got %0h exp 0", tries_left); end
    // IDLE accepts a new start
    do_start(8'h05);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL rm_idle_start got %0h exp 1", busy); end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_start_with_submit();
    test_win_first();
    test_loss();
    test_timeout();
    test_submit_on_timeout();
    test_busy_protect();
    test_reset_motor();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_code_checker
`default_nettype wire
